// File: rtl/uart_rx_if.sv
// Received-byte handshake between uart_rx and its consumer.
// Level-valid data with acknowledge, plus overrun and framing-error status.
interface uart_rx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       overrun;
  logic       frame_error;

  modport master (
    output data,
    output data_valid,
    output overrun,
    output frame_error,
    input  data_ack
  );

  modport slave (
    input  data,
    input  data_valid,
    input  overrun,
    input  frame_error,
    output data_ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a runtime bit period.
// Received bytes are held until acknowledged; overrun and framing errors are flagged.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] bit_period,
  input  logic        serial_in,
  output logic        busy,
  uart_rx_if.master   rx_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        rx;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] bp_q, bp_d;
  logic [15:0] bp_in;
  logic [15:0] half_m1;
  logic [15:0] bp_m1;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        fe_q, fe_d;

  assign rx      = sync_q[SYNC_STAGES-1];
  assign bp_in   = (bit_period < 16'd4) ? 16'd4 : bit_period;
  assign half_m1 = (bp_q >> 1) - 16'd1;
  assign bp_m1   = bp_q - 16'd1;

  // Chain resets to ones so a reset never looks like a start bit
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bp_q    <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bp_q    <= bp_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bp_d    = bp_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fe_d    = 1'b0;

    if (rx_if.data_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rx) begin
          bp_d    = bp_in;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == half_m1) begin
          if (rx) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == bp_m1) begin
          sh_d  = {rx, sh_q[7:1]};
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == bp_m1) begin
          cnt_d = '0;
          if (rx) begin
            // A coincident ack consumes the old byte, so no overrun
            data_d  = sh_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~rx_if.data_ack;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rx) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy              = (state_q != S_IDLE);
  assign rx_if.data        = data_q;
  assign rx_if.data_valid  = valid_q;
  assign rx_if.overrun     = ovr_q;
  assign rx_if.frame_error = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed 8N1 frames drive the line,
// a negedge monitor checks each delivered byte against queued expectations.
module tb_uart_rx;

  typedef struct {
    logic [7:0] d;
    logic       ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] bit_period = 16'd104;
  logic        serial_in = 1'b1;
  logic        busy;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   fe_cnt = 0;

  logic [7:0] d_q = 8'h00;
  logic       v_q = 1'b0;
  logic       fe_q = 1'b0;

  uart_rx_if u_if ();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .bit_period (bit_period),
    .serial_in  (serial_in),
    .busy       (busy),
    .rx_if      (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic ovr);
    exp_t e;
    e.d   = b;
    e.ovr = ovr;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame bits: start, 8 data LSB first, stop; each held bp cycles
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int bp);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = f[i];
      idle(bp);
    end
  endtask

  task automatic ack();
    u_if.data_ack = 1'b1;
    idle(1);
    u_if.data_ack = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (u_if.data_valid && (!v_q || u_if.data !== d_q)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_byte: got %0h expected none",
                 u_if.data);
      end else begin
        e = sb.pop_front();
        chk("rx_data", int'(u_if.data), int'(e.d));
        chk("rx_overrun", int'(u_if.overrun), int'(e.ovr));
      end
    end
    if (u_if.frame_error) begin
      fe_cnt++;
      chk("fe_width", int'(fe_q), 0);
    end
    v_q  <= u_if.data_valid;
    d_q  <= u_if.data;
    fe_q <= u_if.frame_error;
  end

  initial begin
    u_if.data_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    idle(2);
    chk("rst_data", int'(u_if.data), 0);
    chk("rst_valid", int'(u_if.data_valid), 0);
    chk("rst_ovr", int'(u_if.overrun), 0);
    chk("rst_fe", int'(u_if.frame_error), 0);
    chk("rst_busy", int'(busy), 0);

    push(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1, 104);
    chk("a5_valid", int'(u_if.data_valid), 1);
    chk("a5_data", int'(u_if.data), 'hA5);
    chk("a5_busy", int'(busy), 0);
    ack();
    chk("a5_ack_valid", int'(u_if.data_valid), 0);

    push(8'h00, 1'b0);
    push(8'hFF, 1'b0);
    send_frame(8'h00, 1'b1, 104);
    fork
      send_frame(8'hFF, 1'b1, 104);
      ack();
    join
    chk("b2b_data", int'(u_if.data), 'hFF);
    ack();
    chk("b2b_valid", int'(u_if.data_valid), 0);

    serial_in = 1'b0;
    idle(40);
    chk("glitch_busy", int'(busy), 1);
    serial_in = 1'b1;
    idle(200);
    chk("glitch_idle", int'(busy), 0);
    chk("glitch_valid", int'(u_if.data_valid), 0);
    chk("glitch_fe", fe_cnt, 0);

    send_frame(8'h3C, 1'b0, 104);
    idle(500);
    chk("fe_count_1", fe_cnt, 1);
    chk("fe_busy_low", int'(busy), 1);
    chk("fe_valid", int'(u_if.data_valid), 0);
    serial_in = 1'b1;
    idle(10);
    chk("fe_busy_rel", int'(busy), 0);
    push(8'h11, 1'b0);
    send_frame(8'h11, 1'b1, 104);
    chk("after_fe_data", int'(u_if.data), 'h11);
    ack();

    push(8'h12, 1'b0);
    push(8'h34, 1'b1);
    send_frame(8'h12, 1'b1, 104);
    send_frame(8'h34, 1'b1, 104);
    chk("ovr_data", int'(u_if.data), 'h34);
    chk("ovr_valid", int'(u_if.data_valid), 1);
    chk("ovr_flag", int'(u_if.overrun), 1);
    ack();
    chk("ovr_ack_valid", int'(u_if.data_valid), 0);
    chk("ovr_ack_flag", int'(u_if.overrun), 0);

    // Stop sample lands on the 991st edge after the frame starts
    push(8'h78, 1'b0);
    send_frame(8'h78, 1'b1, 104);
    push(8'h56, 1'b0);
    fork
      send_frame(8'h56, 1'b1, 104);
      begin
        idle(989);
        u_if.data_ack = 1'b1;
        idle(1);
        u_if.data_ack = 1'b0;
      end
    join
    chk("coin_data", int'(u_if.data), 'h56);
    chk("coin_valid", int'(u_if.data_valid), 1);
    chk("coin_ovr", int'(u_if.overrun), 0);

    serial_in = 1'b0;
    idle(104);
    serial_in = 1'b0;
    idle(104);
    serial_in = 1'b1;
    idle(104);
    serial_in = 1'b0;
    idle(104);
    serial_in = 1'b1;
    idle(50);
    chk("mid_busy", int'(busy), 1);
    nrst = 1'b0;
    idle(3);
    nrst = 1'b1;
    idle(300);
    chk("mr_data", int'(u_if.data), 0);
    chk("mr_valid", int'(u_if.data_valid), 0);
    chk("mr_ovr", int'(u_if.overrun), 0);
    chk("mr_fe", int'(u_if.frame_error), 0);
    chk("mr_busy", int'(busy), 0);

    push(8'hC3, 1'b0);
    send_frame(8'hC3, 1'b1, 104);
    chk("c3_data", int'(u_if.data), 'hC3);
    ack();

    push(8'h5A, 1'b0);
    fork
      send_frame(8'h5A, 1'b1, 104);
      begin
        idle(300);
        bit_period = 16'd52;
      end
    join
    bit_period = 16'd104;
    chk("bpchg_data", int'(u_if.data), 'h5A);
    ack();

    bit_period = 16'd2;
    push(8'h96, 1'b0);
    send_frame(8'h96, 1'b1, 4);
    idle(10);
    chk("bpmin_data", int'(u_if.data), 'h96);
    ack();
    bit_period = 16'd104;

    idle(20);
    chk("sb_empty", sb.size(), 0);
    chk("fe_total", fe_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
